// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
//   deser_state_e : frame collection state
//   cnt_w()       : width of a counter able to hold 0..width
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } deser_state_e;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry valid/ready holding register for completed words.
// Ports:
//   ck, rst (sync active-low), clr (sync, clears valid, keeps data)
//   load      : a completed word is offered this edge
//   d         : word offered with load
//   ready     : consumer accepts q when valid & ready
//   q, valid  : registered word and its valid flag
//   dropped_c : combinational, the offered word is being discarded (entry full, not draining)
module word_hold_reg #(
    parameter int unsigned W = 9
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic [W-1:0] q,
    output logic         valid,
    output logic         dropped_c
);

    assign dropped_c = load & valid & ~ready;

    // Accept a new word whenever the entry is empty or draining this edge.
    always_ff @(posedge ck) begin
        if (!rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load && (!valid || ready)) begin
            q     <= d;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: collects sin bits qualified by sin_valid
// into WIDTH-bit words and presents them on a valid/ready port.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame
// and the parity_err output travelling with q).
// Ports:
//   ck, rst (sync active-low), clr (sync frame clear)
//   sin, sin_valid : serial bit and its qualifier
//   q, q_valid     : assembled word and its valid flag
//   q_ready        : consumer handshake
//   overrun        : sticky, a completed word was dropped
//   bit_cnt        : bits collected in the current frame
//   parity_err     : (PARITY_CHECK_EN only) parity flag for q
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      sin,
    input  logic                      sin_valid,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    input  logic                      q_ready,
    output logic                      overrun,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
`ifdef PARITY_CHECK_EN
    ,
    output logic                      parity_err
`endif
);

    localparam int unsigned CNT_W  = cnt_w(WIDTH);
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME  = WIDTH + 1;
    localparam int unsigned HOLD_W = WIDTH + 1;
`else
    localparam int unsigned FRAME  = WIDTH;
    localparam int unsigned HOLD_W = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    deser_state_e      state;
    logic [WIDTH-1:0]  sreg;
    logic [WIDTH-1:0]  sreg_shift_c;
    logic              shifting_c;
    logic              last_bit_c;
    logic              load_c;
    logic [HOLD_W-1:0] hold_d_c;
    logic [HOLD_W-1:0] hold_q;
    logic              dropped_c;

    // Next shift-register value and completion detection.
    always_comb begin
        sreg_shift_c = sreg;
        if (MSB_FIRST) begin
            sreg_shift_c = {sreg[WIDTH-2:0], sin};
        end else begin
            sreg_shift_c = {sin, sreg[WIDTH-1:1]};
        end
        shifting_c = (state != S_PARITY);
        last_bit_c = sin_valid && (bit_cnt == LAST_IDX);
        load_c     = rst && !clr && last_bit_c;
`ifdef PARITY_CHECK_EN
        // Final frame bit is the parity bit; the data word is already complete.
        hold_d_c   = {^{sreg, sin}, sreg};
`else
        hold_d_c   = sreg_shift_c;
`endif
    end

    // Frame FSM, bit counter, shift register and sticky overrun.
    always_ff @(posedge ck) begin
        if (!rst) begin
            state   <= S_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            state   <= S_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (dropped_c) begin
                overrun <= 1'b1;
            end
            if (sin_valid) begin
                if (shifting_c) begin
                    sreg <= sreg_shift_c;
                end
                if (last_bit_c) begin
                    bit_cnt <= '0;
                    state   <= S_IDLE;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef PARITY_CHECK_EN
                    state   <= (bit_cnt == CNT_W'(WIDTH - 1)) ? S_PARITY : S_SHIFT;
`else
                    state   <= S_SHIFT;
`endif
                end
            end
        end
    end

    word_hold_reg #(
        .W (HOLD_W)
    ) u_hold (
        .ck        (ck),
        .rst       (rst),
        .clr       (clr),
        .load      (load_c),
        .d         (hold_d_c),
        .ready     (q_ready),
        .q         (hold_q),
        .valid     (q_valid),
        .dropped_c (dropped_c)
    );

    assign q = hold_q[WIDTH-1:0];
`ifdef PARITY_CHECK_EN
    assign parity_err = hold_q[WIDTH];
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer (WIDTH=8), MSB-first and LSB-first instances.
module tb_shift_deserializer;

    localparam int unsigned W = 8;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif

    logic ck = 1'b0;
    logic rst = 1'b0, clr = 1'b0, sin = 1'b0, sin_valid = 1'b0, q_ready = 1'b1;
    logic [W-1:0] q_m, q_l;
    logic qv_m, qv_l, ov_m, ov_l;
    logic [3:0] cnt_m, cnt_l;
    logic pe_m, pe_l;

    shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .ck(ck), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .overrun(ov_m), .bit_cnt(cnt_m)
`ifdef PARITY_CHECK_EN
        , .parity_err(pe_m)
`endif
    );

    shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .ck(ck), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .overrun(ov_l), .bit_cnt(cnt_l)
`ifdef PARITY_CHECK_EN
        , .parity_err(pe_l)
`endif
    );

`ifndef PARITY_CHECK_EN
    assign pe_m = 1'b0;
    assign pe_l = 1'b0;
`endif

    always #5 ck = ~ck;

    // Reference model state: bits of the current frame, one-entry output occupancy, sticky overrun.
    bit         fb[$];
    bit         model_full;
    bit         model_ovr;
    logic [8:0] exp_m[$];
    logic [8:0] exp_l[$];
    bit         mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs, then apply the specified effect of that edge to the model.
    task automatic step(input bit r, input bit c, input bit s, input bit sv, input bit rdy);
        bit         blocked;
        int         ones;
        logic [7:0] wm, wl;
        rst = r; clr = c; sin = s; sin_valid = sv; q_ready = rdy;
        @(posedge ck);
        if (!r || c) begin
            fb.delete();
            model_full = 1'b0;
            model_ovr  = 1'b0;
            exp_m.delete();
            exp_l.delete();
        end else begin
            blocked = model_full && !rdy;
            if (model_full && rdy) model_full = 1'b0;
            if (sv) begin
                fb.push_back(s);
                if (fb.size() == FRAME) begin
                    ones = 0;
                    for (int i = 0; i < int'(FRAME); i++) ones += int'(fb[i]);
                    for (int i = 0; i < int'(W); i++) begin
                        wm[W-1-i] = fb[i];
                        wl[i]     = fb[i];
                    end
`ifndef PARITY_CHECK_EN
                    ones = 0;
`endif
                    if (blocked) begin
                        model_ovr = 1'b1;
                    end else begin
                        exp_m.push_back({1'(ones % 2), wm});
                        exp_l.push_back({1'(ones % 2), wl});
                        model_full = 1'b1;
                    end
                    fb.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] w, input bit pbit, input bit gapped, input bit rdy);
        for (int i = 0; i < int'(FRAME); i++) begin
            step(1'b1, 1'b0, (i < int'(W)) ? w[W-1-i] : pbit, 1'b1, rdy);
            if (gapped) begin
                check("gap_bit_cnt", 32'(cnt_m), 32'(i + 1 == int'(FRAME) ? 0 : i + 1));
                step(1'b1, 1'b0, 1'($urandom), 1'b0, rdy);
            end
        end
    endtask

    // Monitor: status against model every cycle, words popped on handshake.
    always @(negedge ck) begin
        if (mon_en) begin
            check("q_valid_m", 32'(qv_m), 32'(model_full));
            check("q_valid_l", 32'(qv_l), 32'(model_full));
            check("overrun_m", 32'(ov_m), 32'(model_ovr));
            check("overrun_l", 32'(ov_l), 32'(model_ovr));
            check("bit_cnt", 32'(cnt_m), 32'(fb.size()));
            if (qv_m) begin
                check("word_pending", 32'(exp_m.size()), 32'd1);
                if (exp_m.size() != 0) begin
                    check("q_msb_first", 32'({pe_m, q_m}), 32'(exp_m[0]));
                    check("q_lsb_first", 32'({pe_l, q_l}), 32'(exp_l[0]));
                    if (q_ready) begin
                        void'(exp_m.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        // Reset held with active serial input.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("reset_q", 32'(q_m), 32'h0);
        check("reset_q_valid", 32'(qv_m), 32'h0);
        check("reset_bit_cnt", 32'(cnt_m), 32'h0);
        check("reset_overrun", 32'(ov_m), 32'h0);

        // Walking one: valid exactly one cycle after the final bit edge.
        send_frame(8'h80, 1'b1, 1'b0, 1'b1);
        check("walk1_latency_valid", 32'(qv_m), 32'h1);
        check("walk1_msb", 32'(q_m), 32'h80);
        check("walk1_lsb", 32'(q_l), 32'h01);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped stream.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Blocked consumer: second word dropped, overrun set, then cleared by clr.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        check("ovr_q_kept", 32'(q_m), 32'h3C);
        check("ovr_flag", 32'(ov_m), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_q_valid", 32'(qv_m), 32'h0);
        check("clr_overrun", 32'(ov_m), 32'h0);
        check("clr_bit_cnt", 32'(cnt_m), 32'h0);

        // Reset mid-frame leaves no stale bits.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        check("post_reset_word", 32'(q_m), 32'h0F);

        // Back-to-back with ready high: never overruns.
        for (int k = 0; k < 6; k++) send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b1);
        check("b2b_no_overrun", 32'(ov_m), 32'h0);

`ifdef PARITY_CHECK_EN
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("parity_ok", 32'(pe_m), 32'h0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check("parity_bad", 32'(pe_m), 32'h1);
`endif

        // Randomized traffic with random gaps, back-pressure, clears and resets.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 300) != 0, ($urandom % 200) == 0, 1'($urandom),
                 ($urandom % 4) != 0, ($urandom % 3) != 0);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drained", 32'(exp_m.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
